// File: rtl/ddr2_arbiter_pkg.sv
// Shared widths, FSM states and request payload for the two-port DDR2 arbiter.
package ddr2_arbiter_pkg;

  localparam int unsigned ADDR_W = 26;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ddr2_req_fifo.sv
// Per-port request queue; a push is refused whenever the queue was full at the
// start of the cycle, even if the head is popped on the same edge.
module ddr2_req_fifo
  import ddr2_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  req_t push_entry,
  input  logic pop,
  output req_t head_c,
  output logic empty,
  output logic full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    cnt_nxt = cnt + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt   <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == CNT_W'(DEPTH));
    end
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/ddr2_arbiter.sv
// Two-port round-robin front end for a single-command DDR2 controller: one
// command in flight, strobes held until acknowledge, one recovery cycle after.
module ddr2_arbiter
  import ddr2_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_wack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_wack,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_data_in,
  output logic              c_rd_req,
  output logic              c_wr_req,
  input  logic              c_rdy,
  input  logic              c_ack,
  input  logic [DATA_W-1:0] c_data_out
);

  state_t            state, state_nxt;
  logic              gnt, gnt_nxt;
  logic              last_gnt, last_nxt;
  logic [ADDR_W-1:0] c_addr_nxt;
  logic [DATA_W-1:0] c_data_in_nxt;
  logic              c_rd_nxt, c_wr_nxt;
  logic [DATA_W-1:0] p0_rdata_nxt, p1_rdata_nxt;
  logic [1:0]        rvalid_nxt, wack_nxt;
  logic [1:0]        pop;
  logic [1:0]        empty, full;
  logic              sel;
  req_t              sel_entry;
  req_t              head [2];

  ddr2_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk        (clk),
    .rst        (rst),
    .push       (p0_req),
    .push_entry ('{we: p0_we, addr: p0_addr, wdata: p0_wdata}),
    .pop        (pop[0]),
    .head_c     (head[0]),
    .empty      (empty[0]),
    .full       (full[0])
  );

  ddr2_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk        (clk),
    .rst        (rst),
    .push       (p1_req),
    .push_entry ('{we: p1_we, addr: p1_addr, wdata: p1_wdata}),
    .pop        (pop[1]),
    .head_c     (head[1]),
    .empty      (empty[1]),
    .full       (full[1])
  );

  assign p0_ready = ~full[0];
  assign p1_ready = ~full[1];

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    last_nxt      = last_gnt;
    c_addr_nxt    = c_addr;
    c_data_in_nxt = c_data_in;
    c_rd_nxt      = c_rd_req;
    c_wr_nxt      = c_wr_req;
    p0_rdata_nxt  = p0_rdata;
    p1_rdata_nxt  = p1_rdata;
    rvalid_nxt    = 2'b00;
    wack_nxt      = 2'b00;
    pop           = 2'b00;
    sel           = 1'b0;
    sel_entry     = head[0];

    unique case (state)
      S_IDLE: begin
        if (c_rdy && (~empty[0] || ~empty[1])) begin
          // On a tie the port not served last wins; otherwise the only non-empty one.
          sel           = (empty[0] || empty[1]) ? empty[0] : ~last_gnt;
          sel_entry     = sel ? head[1] : head[0];
          gnt_nxt       = sel;
          last_nxt      = sel;
          c_addr_nxt    = sel_entry.addr;
          c_data_in_nxt = sel_entry.wdata;
          c_rd_nxt      = ~sel_entry.we;
          c_wr_nxt      = sel_entry.we;
          state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (c_ack) begin
          c_rd_nxt  = 1'b0;
          c_wr_nxt  = 1'b0;
          pop[gnt]  = 1'b1;
          if (c_rd_req) begin
            if (gnt) p1_rdata_nxt = c_data_out;
            else     p0_rdata_nxt = c_data_out;
            rvalid_nxt[gnt] = 1'b1;
          end else begin
            wack_nxt[gnt] = 1'b1;
          end
          state_nxt = S_RECOVER;
        end
      end
      S_RECOVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      gnt       <= 1'b0;
      last_gnt  <= 1'b1;
      c_addr    <= '0;
      c_data_in <= '0;
      c_rd_req  <= 1'b0;
      c_wr_req  <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_wack   <= 1'b0;
      p1_wack   <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      last_gnt  <= last_nxt;
      c_addr    <= c_addr_nxt;
      c_data_in <= c_data_in_nxt;
      c_rd_req  <= c_rd_nxt;
      c_wr_req  <= c_wr_nxt;
      p0_rdata  <= p0_rdata_nxt;
      p1_rdata  <= p1_rdata_nxt;
      p0_rvalid <= rvalid_nxt[0];
      p1_rvalid <= rvalid_nxt[1];
      p0_wack   <= wack_nxt[0];
      p1_wack   <= wack_nxt[1];
    end
  end

endmodule
